// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Groups the hazard/handshake requests and the stage control outputs of the
// pipeline stall/flush sequencer into one bundle.
//   master : drives the requests and reads the controls (core / testbench side)
//   slave  : reads the requests and drives the controls (pipeline_ctrl side)
// Requests : load_use_stall, branch_taken, imem_ready, dmem_req, dmem_ready,
//            halt_req, resume
// Controls : pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
//            id_ex_flush, mem_wb_flush, halted, bus_error, stall_cnt, flush_cnt
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;
    logic        load_use_stall;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_ready;
    logic        halt_req;
    logic        resume;

    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_flush;
    logic        halted;
    logic        bus_error;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output load_use_stall, branch_taken, imem_ready, dmem_req, dmem_ready,
               halt_req, resume,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_flush, mem_wb_flush, halted, bus_error, stall_cnt, flush_cnt
    );

    modport slave (
        input  load_use_stall, branch_taken, imem_ready, dmem_req, dmem_ready,
               halt_req, resume,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_flush, mem_wb_flush, halted, bus_error, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage RV32I pipeline. Decodes the
// load-use stall, EX redirect, instruction/data memory waits and WB halt
// request into the PC enable and per-stage register enable/flush controls.
// Owns the RUN/HALT state machine and a data-memory timeout watchdog.
//
// Parameters:
//   DMEM_TIMEOUT  max consecutive data-memory wait cycles before bus error
// Ports:
//   clk   pipeline clock
//   rst   asynchronous, active-high reset
//   bus   pipeline_ctrl_if.slave (requests in, stage controls/status out)
// Build option:
//   PIPE_CTRL_PERF_EN  when defined, adds saturating stall/redirect counters;
//                      otherwise stall_cnt/flush_cnt are tied to zero.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);

    typedef enum logic {RUN, HALT} state_t;

    localparam int                  WAIT_W    = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              bus_error;
    logic              freeze;
    logic              timeout;

    // Raw decode before the flush-implies-enable override.
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush;

    // A MEM-stage access still waiting on data memory freezes the whole pipe.
    assign freeze  = (state == RUN) && bus.dmem_req && !bus.dmem_ready;
    assign timeout = freeze && (wait_cnt == WAIT_LAST);

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // ----------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                // Freeze masks halt_req; the halt is taken once memory answers.
                if (timeout)                    state_next = HALT;
                else if (!freeze && bus.halt_req) state_next = HALT;
            end
            HALT: begin
                if (bus.resume) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // --------------------------------------------------------- output decode
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (state == RUN) begin
            if (freeze) begin
                // Hold everything upstream; WB receives a bubble each cycle.
                mem_wb_flush = 1'b1;
            end else if (bus.branch_taken) begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (bus.load_use_stall) begin
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else if (!bus.imem_ready) begin
                {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
                if_id_flush = 1'b1;
            end else begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            end
        end
    end

    // A flush loads the bubble into the register, so it must also be written.
    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en  | if_id_flush;
    assign bus.id_ex_en     = id_ex_en  | id_ex_flush;
    assign bus.ex_mem_en    = ex_mem_en;
    assign bus.mem_wb_en    = mem_wb_en | mem_wb_flush;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.halted       = (state == HALT);
    assign bus.bus_error    = bus_error;

    // -------------------------------------------------------------- watchdog
    // Counts consecutive freeze cycles; any non-freeze cycle (incl. HALT) clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         wait_cnt <= '0;
        else if (freeze) wait_cnt <= wait_cnt + 1'b1;
        else             wait_cnt <= '0;
    end

    // Sticky until the debugger resumes the core out of HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                bus_error <= 1'b0;
        else if (timeout)                       bus_error <= 1'b1;
        else if (state == HALT && bus.resume)   bus_error <= 1'b0;
    end

    // ------------------------------------------------------ perf counters
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (state == RUN && !pc_en && stall_q != '1)
                stall_q <= stall_q + 32'd1;
            if (state == RUN && !freeze && bus.branch_taken && flush_q != '1)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl with DMEM_TIMEOUT = 4. Expected
// control vectors are pushed to a scoreboard queue as each cycle's stimulus is
// driven and popped for comparison at the mid-cycle sample point. Counter
// expectations come from a small bench-side tally (zero when
// PIPE_CTRL_PERF_EN is undefined).
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int T = 4;

    // Stimulus: {load_use_stall, branch_taken, imem_ready, dmem_req,
    //            dmem_ready, halt_req, resume}
    localparam logic [6:0] IDLE      = 7'b0010000;
    localparam logic [6:0] LU        = 7'b1010000;
    localparam logic [6:0] BR_LU     = 7'b1110000;
    localparam logic [6:0] BR_IMW    = 7'b0100000;
    localparam logic [6:0] IMW       = 7'b0000000;
    localparam logic [6:0] FRZ       = 7'b0011000;
    localparam logic [6:0] FRZ_BR_LU = 7'b1111000;
    localparam logic [6:0] MEM_OK    = 7'b0011100;
    localparam logic [6:0] HREQ      = 7'b0010010;
    localparam logic [6:0] HREQ_BR   = 7'b0110010;
    localparam logic [6:0] RES       = 7'b0010001;
    localparam logic [6:0] FRZ_H     = 7'b0011010;
    localparam logic [6:0] MEM_OK_H  = 7'b0011110;

    // Expected: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    //            if_id_flush, id_ex_flush, mem_wb_flush, halted, bus_error}
    localparam logic [9:0] NORMAL    = 10'b11111_000_00;
    localparam logic [9:0] FREEZE    = 10'b00001_001_00;
    localparam logic [9:0] BRANCH    = 10'b11111_110_00;
    localparam logic [9:0] LOADUSE   = 10'b00111_010_00;
    localparam logic [9:0] IMEMWAIT  = 10'b01111_100_00;
    localparam logic [9:0] HALTED    = 10'b00000_000_10;
    localparam logic [9:0] HALTED_BE = 10'b00000_000_11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [9:0]  sb[$];
    logic [31:0] stall_m = '0;
    logic [31:0] flush_m = '0;

    pipeline_ctrl_if ifc ();

    pipeline_ctrl #(.DMEM_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {ifc.pc_en, ifc.if_id_en, ifc.id_ex_en, ifc.ex_mem_en,
                ifc.mem_wb_en, ifc.if_id_flush, ifc.id_ex_flush,
                ifc.mem_wb_flush, ifc.halted, ifc.bus_error};
    endfunction

    function automatic logic [63:0] exp_cnt();
`ifdef PIPE_CTRL_PERF_EN
        return {stall_m, flush_m};
`else
        return 64'd0;
`endif
    endfunction

    task automatic drive(input logic [6:0] in);
        {ifc.load_use_stall, ifc.branch_taken, ifc.imem_ready, ifc.dmem_req,
         ifc.dmem_ready, ifc.halt_req, ifc.resume} = in;
    endtask

    // One cycle: drive at negedge, record expectation, move to sample point.
    task automatic step(input logic [6:0] in, input logic [9:0] exp);
        @(negedge clk);
        drive(in);
        sb.push_back(exp);
        #2;
    endtask

    // Tally the counters implied by an expected RUN-mode cycle.
    task automatic account(input logic [9:0] e);
        if (!e[9] && !e[1] && stall_m != '1) stall_m = stall_m + 32'd1;
        if (e == BRANCH && flush_m != '1)    flush_m = flush_m + 32'd1;
    endtask

    task automatic test_reset();
        drive(IDLE);
        #1;
        tests_run++;
        if (outs() !== NORMAL) begin
            tests_failed++;
            $display("FAIL reset_decode got %b want %b", outs(), NORMAL);
        end
        tests_run++;
        if ({ifc.stall_cnt, ifc.flush_cnt} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_counters got %h want 0", {ifc.stall_cnt, ifc.flush_cnt});
        end
        drive(FRZ);
        #1;
        tests_run++;
        if (outs() !== FREEZE) begin
            tests_failed++;
            $display("FAIL reset_freeze_decode got %b want %b", outs(), FREEZE);
        end
        drive(IDLE);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [6:0] st [2];
        logic [9:0] ex [2];
        logic [9:0] e;
        st = '{LU, IDLE};
        ex = '{LOADUSE, NORMAL};
        for (int i = 0; i < 2; i++) begin
            step(st[i], ex[i]);
            e = sb.pop_front();
            tests_run++;
            if (outs() !== e) begin
                tests_failed++;
                $display("FAIL load_use[%0d] got %b want %b", i, outs(), e);
            end
            tests_run++;
            if ({ifc.stall_cnt, ifc.flush_cnt} !== exp_cnt()) begin
                tests_failed++;
                $display("FAIL load_use_cnt[%0d] got %h want %h", i, {ifc.stall_cnt, ifc.flush_cnt}, exp_cnt());
            end
            account(e);
        end
    endtask

    task automatic test_branch();
        logic [6:0] st [4];
        logic [9:0] ex [4];
        logic [9:0] e;
        st = '{BR_LU, BR_IMW, IMW, IDLE};
        ex = '{BRANCH, BRANCH, IMEMWAIT, NORMAL};
        for (int i = 0; i < 4; i++) begin
            step(st[i], ex[i]);
            e = sb.pop_front();
            tests_run++;
            if (outs() !== e) begin
                tests_failed++;
                $display("FAIL branch[%0d] got %b want %b", i, outs(), e);
            end
            tests_run++;
            if ({ifc.stall_cnt, ifc.flush_cnt} !== exp_cnt()) begin
                tests_failed++;
                $display("FAIL branch_cnt[%0d] got %h want %h", i, {ifc.stall_cnt, ifc.flush_cnt}, exp_cnt());
            end
            account(e);
        end
    endtask

    // Two freezes of T-1 cycles separated by a normal cycle must not time out.
    task automatic test_freeze();
        logic [6:0] st [9];
        logic [9:0] ex [9];
        logic [9:0] e;
        st = '{FRZ_BR_LU, FRZ, FRZ, MEM_OK, FRZ, FRZ, FRZ, MEM_OK, IDLE};
        ex = '{FREEZE, FREEZE, FREEZE, NORMAL, FREEZE, FREEZE, FREEZE, NORMAL, NORMAL};
        for (int i = 0; i < 9; i++) begin
            step(st[i], ex[i]);
            e = sb.pop_front();
            tests_run++;
            if (outs() !== e) begin
                tests_failed++;
                $display("FAIL freeze[%0d] got %b want %b", i, outs(), e);
            end
            tests_run++;
            if ({ifc.stall_cnt, ifc.flush_cnt} !== exp_cnt()) begin
                tests_failed++;
                $display("FAIL freeze_cnt[%0d] got %h want %h", i, {ifc.stall_cnt, ifc.flush_cnt}, exp_cnt());
            end
            account(e);
        end
    endtask

    task automatic test_timeout();
        logic [6:0] st [7];
        logic [9:0] ex [7];
        logic [9:0] e;
        st = '{FRZ, FRZ, FRZ, FRZ, FRZ, RES, IDLE};
        ex = '{FREEZE, FREEZE, FREEZE, FREEZE, HALTED_BE, HALTED_BE, NORMAL};
        for (int i = 0; i < 7; i++) begin
            step(st[i], ex[i]);
            e = sb.pop_front();
            tests_run++;
            if (outs() !== e) begin
                tests_failed++;
                $display("FAIL timeout[%0d] got %b want %b", i, outs(), e);
            end
            tests_run++;
            if ({ifc.stall_cnt, ifc.flush_cnt} !== exp_cnt()) begin
                tests_failed++;
                $display("FAIL timeout_cnt[%0d] got %h want %h", i, {ifc.stall_cnt, ifc.flush_cnt}, exp_cnt());
            end
            account(e);
        end
    endtask

    task automatic test_halt();
        logic [6:0] st [11];
        logic [9:0] ex [11];
        logic [9:0] e;
        st = '{HREQ, IDLE, HREQ_BR, RES, IDLE, FRZ_H, FRZ_H, MEM_OK_H, IDLE, RES, IDLE};
        ex = '{NORMAL, HALTED, HALTED, HALTED, NORMAL, FREEZE, FREEZE, NORMAL,
               HALTED, HALTED, NORMAL};
        for (int i = 0; i < 11; i++) begin
            step(st[i], ex[i]);
            e = sb.pop_front();
            tests_run++;
            if (outs() !== e) begin
                tests_failed++;
                $display("FAIL halt[%0d] got %b want %b", i, outs(), e);
            end
            tests_run++;
            if ({ifc.stall_cnt, ifc.flush_cnt} !== exp_cnt()) begin
                tests_failed++;
                $display("FAIL halt_cnt[%0d] got %h want %h", i, {ifc.stall_cnt, ifc.flush_cnt}, exp_cnt());
            end
            account(e);
        end
    endtask

    // Reach HALT with bus_error set, then reset between clock edges.
    task automatic test_async_reset();
        logic [6:0] st [5];
        logic [9:0] ex [5];
        logic [9:0] e;
        st = '{BR_LU, FRZ, FRZ, FRZ, FRZ};
        ex = '{BRANCH, FREEZE, FREEZE, FREEZE, FREEZE};
        for (int i = 0; i < 5; i++) begin
            step(st[i], ex[i]);
            e = sb.pop_front();
            tests_run++;
            if (outs() !== e) begin
                tests_failed++;
                $display("FAIL arst_setup[%0d] got %b want %b", i, outs(), e);
            end
            account(e);
        end
        step(IDLE, HALTED_BE);
        e = sb.pop_front();
        tests_run++;
        if (outs() !== e) begin
            tests_failed++;
            $display("FAIL arst_halted got %b want %b", outs(), e);
        end
        tests_run++;
        if ({ifc.stall_cnt, ifc.flush_cnt} !== exp_cnt()) begin
            tests_failed++;
            $display("FAIL arst_pre_cnt got %h want %h", {ifc.stall_cnt, ifc.flush_cnt}, exp_cnt());
        end
        rst = 1'b1;
        #1;
        stall_m = '0;
        flush_m = '0;
        tests_run++;
        if (outs() !== NORMAL) begin
            tests_failed++;
            $display("FAIL arst_outputs got %b want %b", outs(), NORMAL);
        end
        tests_run++;
        if ({ifc.stall_cnt, ifc.flush_cnt} !== 64'd0) begin
            tests_failed++;
            $display("FAIL arst_counters got %h want 0", {ifc.stall_cnt, ifc.flush_cnt});
        end
        #1;
        rst = 1'b0;
        step(IDLE, NORMAL);
        e = sb.pop_front();
        tests_run++;
        if (outs() !== e) begin
            tests_failed++;
            $display("FAIL arst_after got %b want %b", outs(), e);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_freeze();
        test_timeout();
        test_halt();
        test_async_reset();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
